// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU data port, host/DMA port and dmem port.
// slave is the arbiter's view; master is the view of the surrounding system.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        h_valid;
  logic        h_we;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;
  logic        h_ready;
  logic        h_rvalid;
  logic [31:0] h_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  h_valid, h_we, h_addr, h_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, h_ready, h_rvalid, h_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output h_valid, h_we, h_addr, h_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, h_ready, h_rvalid, h_rdata,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU owns memory, host uses idle cycles or a forced burst after MAX_WAIT.
// Optional DMEM_ARB_STATS_EN adds saturating stall_cycles / host_xfers counters.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]    stall_cycles,
  output logic [31:0]    host_xfers
`endif
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [3:0] BEAT_LIMIT = 4'(BURST_LEN);

  typedef enum logic {S_CPU, S_BURST} state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [3:0] beat_cnt, beat_nxt;
  logic       grant_host;
  logic       forced;
  logic       xfer;

  assign grant_host = bus.h_valid &&
                      (!bus.cpu_req || state == S_BURST || wait_cnt == WAIT_LIMIT);
  assign forced     = bus.cpu_req && bus.h_valid && wait_cnt == WAIT_LIMIT;
  assign xfer       = grant_host;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_CPU;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    wait_nxt  = wait_cnt;
    if (!bus.h_valid || xfer)
      wait_nxt = '0;
    else if (wait_cnt != WAIT_LIMIT)
      wait_nxt = wait_cnt + 8'd1;
    case (state)
      S_CPU: begin
        // The forcing cycle is itself beat 1, so a one-beat burst never enters S_BURST.
        if (forced && BEAT_LIMIT > 4'd1) begin
          state_nxt = S_BURST;
          beat_nxt  = 4'd1;
        end
      end
      S_BURST: begin
        if (!bus.h_valid || beat_cnt + 4'd1 == BEAT_LIMIT) begin
          state_nxt = S_CPU;
          beat_nxt  = '0;
        end else begin
          beat_nxt  = beat_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = S_CPU;
        beat_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    bus.h_ready   = grant_host;
    bus.cpu_stall = bus.cpu_req && grant_host;
    bus.cpu_rdata = bus.mem_rdata;
    if (grant_host) begin
      bus.mem_we    = bus.h_we;
      bus.mem_addr  = bus.h_addr;
      bus.mem_wdata = bus.h_wdata;
    end else begin
      bus.mem_we    = bus.cpu_req && bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.h_rvalid <= 1'b0;
      bus.h_rdata  <= '0;
    end else begin
      bus.h_rvalid <= xfer && !bus.h_we;
      if (xfer && !bus.h_we)
        bus.h_rdata <= bus.mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      host_xfers   <= '0;
    end else begin
      if (bus.cpu_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (xfer && host_xfers != '1)
        host_xfers <= host_xfers + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (MAX_WAIT=8, BURST_LEN=4) with a per-cycle expectation queue.
// Also checks the stats counters when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;
  logic clk;
  logic reset;
  dmem_arbiter_if bus ();
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] host_xfers;
`endif

  dmem_arbiter #(.MAX_WAIT(8), .BURST_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .host_xfers   (host_xfers)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: combinational read, write on rising edge
  logic [31:0] mem [0:255];
  always_comb bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  typedef struct {
    logic        hs;
    logic        rdy;
    logic        stl;
    logic        rd;
    logic [31:0] crd;
    logic        rv;
    logic [31:0] hrd;
    logic        st;
    logic [31:0] sc;
    logic [31:0] hx;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int unsigned checks;
  int unsigned failures;
  logic        want_hs, want_st, drv_rst;
  logic [31:0] exp_sc, exp_hx;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] CF = 32'hCAFEF00D;
  localparam logic [31:0] H1 = 32'h12345678;
  localparam logic [31:0] H2 = 32'h9ABCDEF0;
  localparam logic [31:0] L  = 32'h0000_0040;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      if (m_e.hs) begin
        chk("h_ready", 32'(bus.h_ready), 32'(m_e.rdy));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(m_e.stl));
      end
      if (m_e.rd) chk("cpu_rdata", bus.cpu_rdata, m_e.crd);
      chk("h_rvalid", 32'(bus.h_rvalid), 32'(m_e.rv));
      if (m_e.rv && bus.h_rvalid) chk("h_rdata", bus.h_rdata, m_e.hrd);
`ifdef DMEM_ARB_STATS_EN
      if (m_e.st) begin
        chk("stall_cycles", stall_cycles, m_e.sc);
        chk("host_xfers", host_xfers, m_e.hx);
      end
`endif
    end
  end

  task automatic cyc(input logic rq, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic hv, input logic hw, input logic [31:0] ha, input logic [31:0] hd,
                     input logic rdy, input logic stl, input logic rd, input logic [31:0] crd,
                     input logic rv, input logic [31:0] hrd);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = drv_rst;
    bus.cpu_req   = rq;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.h_valid   = hv;
    bus.h_we      = hw;
    bus.h_addr    = ha;
    bus.h_wdata   = hd;
    e.hs = want_hs; e.rdy = rdy; e.stl = stl;
    e.rd = rd;      e.crd = crd;
    e.rv = rv;      e.hrd = hrd;
    e.st = want_st; e.sc = exp_sc; e.hx = exp_hx;
    q.push_back(e);
    want_hs = 1'b1;
    want_st = 1'b0;
    drv_rst = 1'b0;
  endtask

  task automatic do_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.h_valid = 1'b0; bus.h_we = 1'b0;   bus.h_addr = '0;   bus.h_wdata = '0;
    end
  endtask

  task automatic expect_stats(input logic [31:0] sc, input logic [31:0] hx);
    want_st = 1'b1;
    exp_sc  = sc;
    exp_hx  = hx;
  endtask

  initial begin
    checks = 0; failures = 0;
    want_hs = 1'b1; want_st = 1'b0; drv_rst = 1'b0;
    exp_sc = '0; exp_hx = '0;
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.h_valid = 1'b0; bus.h_we = 1'b0;   bus.h_addr = '0;   bus.h_wdata = '0;
    do_reset();

    // reset state, then CPU store/load with no host traffic
    expect_stats(0, 0);
    cyc(0,0,0,0,   0,0,0,0,   0,0, 0,0,  0,0);
    cyc(1,1,L,DB,  0,0,0,0,   0,0, 0,0,  0,0);
    cyc(1,0,L,0,   0,0,0,0,   0,0, 1,DB, 0,0);

    // idle-cycle host read; following cycle shows S_CPU rules still apply
    cyc(0,0,0,0,   1,0,L,0,   1,0, 0,0,  0,0);
    cyc(1,0,L,0,   1,0,L,0,   0,0, 1,DB, 1,DB);
    cyc(1,0,L,0,   0,0,0,0,   0,0, 1,DB, 0,0);

    // starvation: 6 host write beats under continuous cpu_req
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1,0,L,0, 1,1,32'h80,32'hA0, 0,0, 1,DB, 0,0);
    for (int k = 0; k < 4; k++) cyc(1,0,L,0, 1,1,32'h80 + 32'(4*k),32'hA0 + 32'(k), 1,1, 0,0, 0,0);
    for (int i = 0; i < 8; i++) cyc(1,0,L,0, 1,1,32'h90,32'hA4, 0,0, 1,DB, 0,0);
    cyc(1,0,L,0, 1,1,32'h90,32'hA4, 1,1, 0,0, 0,0);
    cyc(1,0,L,0, 1,1,32'h94,32'hA5, 1,1, 0,0, 0,0);
    expect_stats(6, 6);
    cyc(1,0,L,0, 0,0,0,0, 0,0, 1,DB, 0,0);

    // read back first and last burst writes in idle cycles
    cyc(0,0,0,0, 1,0,32'h80,0, 1,0, 0,0, 0,0);
    cyc(0,0,0,0, 1,0,32'h94,0, 1,0, 0,0, 1,32'hA0);
    cyc(0,0,0,0, 0,0,0,0,      0,0, 0,0, 1,32'hA5);

    // early exit after 2 forced beats; CPU store stalled then committed
    for (int i = 0; i < 8; i++) cyc(1,0,L,0, 1,1,32'hC4,H1, 0,0, 1,DB, 0,0);
    cyc(1,1,32'hC0,CF, 1,1,32'hC4,H1, 1,1, 0,0, 0,0);
    cyc(1,1,32'hC0,CF, 1,1,32'hC8,H2, 1,1, 0,0, 0,0);
    cyc(1,1,32'hC0,CF, 0,0,0,0,       0,0, 0,0, 0,0);
    cyc(1,0,32'hC0,0,  1,0,32'hC4,0,  0,0, 1,CF, 0,0);
    for (int i = 0; i < 7; i++) cyc(1,0,L,0, 1,0,32'hC4,0, 0,0, 1,DB, 0,0);
    cyc(1,0,L,0, 1,0,32'hC4,0, 1,1, 0,0, 0,0);
    cyc(1,0,L,0, 0,0,0,0,      0,0, 1,DB, 1,H1);

    // reset asserted after beat 2 of a forced read burst
    for (int i = 0; i < 8; i++) cyc(1,0,L,0, 1,0,L,0, 0,0, 1,DB, 0,0);
    cyc(1,0,L,0, 1,0,L,0, 1,1, 0,0, 0,0);
    cyc(1,0,L,0, 1,0,L,0, 1,1, 0,0, 1,DB);
    drv_rst = 1'b1;
    want_hs = 1'b0;
    cyc(1,0,L,0, 1,0,L,0, 0,0, 0,0, 1,DB);
    expect_stats(0, 0);
    cyc(1,0,L,0, 1,0,L,0, 0,0, 1,DB, 0,0);
    for (int i = 0; i < 7; i++) cyc(1,0,L,0, 1,0,L,0, 0,0, 1,DB, 0,0);
    cyc(1,0,L,0, 1,0,L,0, 1,1, 0,0, 0,0);
    cyc(1,0,L,0, 0,0,0,0, 0,0, 1,DB, 1,DB);

    @(posedge clk);
    #6;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d entries expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter placed between the `kodd` core's data port, a host/DMA port, and `dmem`. The CPU owns the memory by default. The host is served in idle CPU cycles, and after a bounded wait it is given a forced burst that stalls the CPU. Memory reads stay combinational, as `dmem` provides them. Host read data is registered and returned one cycle after the transfer.

## Interface
Parameters:
- `MAX_WAIT`, 8: consecutive blocked host cycles before a forced grant; legal range 1..255.
- `BURST_LEN`, 4: maximum host beats per forced burst; legal range 1..15.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access this cycle (load or store).
- `cpu_we` in 1: CPU store.
- `cpu_addr` in 32: CPU byte address.
- `cpu_wdata` in 32: CPU store data.
- `cpu_rdata` out 32: CPU load data.
- `cpu_stall` out 1: CPU must hold its pipeline and request.
- `h_valid` in 1: host request valid.
- `h_we` in 1: host write.
- `h_addr` in 32: host address.
- `h_wdata` in 32: host write data.
- `h_ready` out 1: host transfer accepted this cycle.
- `h_rvalid` out 1: registered host read data is valid.
- `h_rdata` out 32: registered host read data.
- `mem_we` out 1: to `dmem`.
- `mem_addr` out 32: to `dmem`.
- `mem_wdata` out 32: to `dmem`.
- `mem_rdata` in 32: from `dmem`; combinational read.

## Operation
- States: `S_CPU` (reset state) and `S_BURST`.
- `grant_host = h_valid && (!cpu_req || state==S_BURST || wait_cnt==MAX_WAIT)`.
- `h_ready = grant_host`. A transfer occurs when `h_valid && h_ready`.
- `cpu_stall = cpu_req && grant_host`.
- Memory mux:
  - With `grant_host`, memory takes the `h_*` signals.
  - Otherwise it takes the `cpu_*` signals.
  - `mem_we = grant_host ? h_we : (cpu_req && cpu_we)`.
- `cpu_rdata = mem_rdata`. This is valid only when `cpu_req && !cpu_stall`.
- `wait_cnt` (8 bit) behaviour:
  - Increments when `h_valid && !grant_host`, saturating at `MAX_WAIT`.
  - Clears on any host transfer or when `h_valid==0`.
- `S_CPU` → `S_BURST` on a forced grant, i.e. `cpu_req && h_valid && wait_cnt==MAX_WAIT`. `beat_cnt` is set to 1.
- In `S_BURST`:
  - Each transfer increments `beat_cnt`.
  - Return to `S_CPU` after the transfer that makes `beat_cnt==BURST_LEN`, or on any cycle with `h_valid==0`.
  - `beat_cnt` clears on exit.
- Idle-cycle host grants (`!cpu_req`) are not bursts; they do not change state.
- Host read on transfer: `h_rdata <= mem_rdata` and `h_rvalid <= 1` on the next edge. Otherwise `h_rvalid <= 0` and `h_rdata` holds its value.
- CPU contract: while `cpu_stall==1`, the CPU holds `cpu_req/cpu_we/cpu_addr/cpu_wdata` stable. The arbiter never writes memory with CPU signals during a stall.
- Reset values:
  - State `S_CPU`.
  - `wait_cnt=0`, `beat_cnt=0`.
  - `h_rvalid=0`, `h_rdata=0`.
  - Stat counters 0.
- Reset asserted mid-burst: the next cycle is in `S_CPU` and any pending `h_rvalid` is dropped.

## Timing
- CPU path is purely combinational. There is no added latency when the CPU is not stalled, so the CPU single-cycle load/store behaviour is preserved.
- Host write: committed on the edge ending its `h_ready` cycle.
- Host read: `h_rvalid` pulses exactly one cycle after the accepting cycle.
- Worst-case host wait under continuous `cpu_req`: `MAX_WAIT` cycles, then up to `BURST_LEN` back-to-back beats.
- Worst-case CPU stall per forced burst: `BURST_LEN` cycles.
- Simultaneous CPU store and host write in a forced cycle: only the host write reaches `dmem`. The CPU store completes on the first unstalled cycle.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - Adds output `stall_cycles[31:0]`, which counts cycles with `cpu_stall==1`.
  - Adds output `host_xfers[31:0]`, which counts host transfers.
  - Both saturate at `32'hFFFF_FFFF` and clear on `reset`.
- `DMEM_ARB_STATS_EN` undefined: neither port nor either counter exists. Arbitration behaviour is identical in both builds.

## Test plan
- **CPU only:** `cpu_req=1, cpu_we=1, cpu_addr=0x40, cpu_wdata=0xDEADBEEF`, then a load from 0x40.
  - `cpu_stall` stays 0 throughout.
  - `cpu_rdata=0xDEADBEEF` in the load cycle.
- **Idle-cycle host read:** `cpu_req=0, h_valid=1, h_we=0, h_addr=0x40`.
  - `h_ready=1` in the same cycle.
  - The next cycle has `h_rvalid=1, h_rdata=0xDEADBEEF`.
  - State remains `S_CPU`.
- **Starvation (MAX_WAIT=8, BURST_LEN=4):** `cpu_req` held at 1 and `h_valid` held at 1 with 6 write beats.
  - `h_ready=0` for 8 cycles.
  - Then 4 consecutive `h_ready=1` cycles with `cpu_stall=1`.
  - Then 8 blocked cycles again before the remaining 2 beats.
- **Burst early exit:** `h_valid` drops after 2 forced beats.
  - State returns to `S_CPU` the following cycle.
  - `cpu_stall=0` that cycle.
  - `wait_cnt=0`.
- **Reset mid-burst:** assert `reset` after beat 2.
  - Next cycle: `h_ready` follows `S_CPU` rules, `h_rvalid=0`, `wait_cnt=0`.
  - With `DMEM_ARB_STATS_EN`, both counters read 0.
- **Stats (`DMEM_ARB_STATS_EN`):** run the starvation scenario.
  - `stall_cycles=6`.
  - `host_xfers=6`.
